wb_unit: RTL and testbench
==========================

# wb_unit

Writeback unit that owns the single write port of the register file. Arbitrates each cycle between single-cycle ALU results and variable-latency load returns, buffering loads that lose arbitration. Keeps a per-register scoreboard of outstanding loads so decode can stall on load-use hazards. Sits between execute/memory and the register file; its registered outputs drive `regWrite`, `writeRegAdd` and `writeRegData` directly.

## Interface
- `WIDTH`, default `` `width `` (32): data width.
- `DEPTH_REG`, default `` `depthReg `` (8): register count; address type is `regAddr`.
- `QDEPTH`, default 4: load-return queue depth, power of two, ≥2.

- `clk`  in  1  clock, all state on rising edge.
- `rst`  in  1  reset, synchronous, active-low.
- `alu_valid`  in  1  ALU result present this cycle; cannot be stalled.
- `alu_dest`  in  regAddr  ALU destination register.
- `alu_data`  in  WIDTH  ALU result.
- `ld_issue`  in  1  decode issued a load this cycle.
- `ld_issue_dest`  in  regAddr  destination of the issued load.
- `ld_valid`  in  1  load data returning.
- `ld_dest`  in  regAddr  load destination.
- `ld_data`  in  WIDTH  load data.
- `ld_ready`  out  1  load return accepted when `ld_valid && ld_ready`.
- `regWrite`  out  1  write enable to the register file.
- `writeRegAdd`  out  regAddr  write address.
- `writeRegData`  out  WIDTH  write data.
- `busy`  out  DEPTH_REG  bit i set while a load to register i is outstanding.
- `q_count`  out  clog2(QDEPTH)+1  queue occupancy.

## Operation
- Port request sources per cycle, priority order: ALU (`alu_valid && alu_dest != 0`), queue head (`q_count != 0`), load bypass (`q_count == 0 && ld_valid`).
- ALU with `alu_dest == 0`: no request; port goes to the next source.
- Winner is registered onto `regWrite/writeRegAdd/writeRegData`; with no winner, `regWrite = 0` and address/data hold.
- Accepted load not winning the port is pushed onto the queue tail; queue head pops only when it wins. FIFO order is preserved: no load overtakes an earlier one.
- Bypass: empty queue, no ALU request, accepted load → written directly, not enqueued.
- Load with `ld_dest == 0`: accepted and consumed with no write; when popped or bypassed, it causes no write and frees the port that cycle.
- `ld_ready = rst && (q_count < QDEPTH)`; registered state only, no combinational dependence on `ld_valid` or `alu_valid`.
- Scoreboard: `ld_issue && ld_issue_dest != 0` sets `busy[ld_issue_dest]`. The cycle a load's write is registered to the port clears `busy[dest]`. Set and clear of the same bit in one cycle: set wins.
- Protocol violations, flagged by bench assertions and undefined in RTL: `ld_issue` to a register already busy; ALU write to a busy register; `ld_valid` for a register not busy.

## Timing
- Reset (`rst == 0` at edge): `regWrite = 0`, `writeRegAdd = 0`, `writeRegData = 0`, `busy = 0`, `q_count = 0`, queue pointers 0. `ld_ready = 0` while `rst` is low.
- Reset mid-operation flushes the queue and scoreboard. Outstanding loads are discarded, and no write occurs on the cycle after reset.
- Latency: ALU 1 cycle; bypassed load 1 cycle; queued load ≥2 cycles.
- `busy` is visible the cycle after `ld_issue`. It clears the same edge `regWrite` rises for that load.
- Push and pop in the same cycle: `q_count` unchanged.
- Full queue: `ld_ready = 0`; the returning source must hold `ld_valid`.
- Sustained ALU traffic starves the queue. This is accepted by design, because decode stalls on `busy`.

## Structure
- Package `def`: `regAddr` (existing), new `wb_entry_t` struct {`regAddr dest`; `logic [`width-1:0] data`}. Macros `width`, `depthReg` stay in `param.sv`.
- Sub-module `wb_fifo`: parameterised queue of `wb_entry_t` with push, pop, count, full, empty; synchronous active-low reset.
- Top module: arbitration mux, output registers, scoreboard.

## Test plan
- Reset: hold `rst = 0` 2 cycles with `ld_valid = 1` → all outputs 0, `ld_ready = 0`; after release, `ld_ready = 1`, `q_count = 0`.
- ALU alone: `alu_valid`, dest 3, data 0xDEADBEEF → next cycle `regWrite = 1`, `writeRegAdd = 3`, `writeRegData = 0xDEADBEEF`. Same with dest 0 → `regWrite = 0`.
- Conflict: `ld_issue` r5; later, same cycle ALU r2 = 0x11 and load r5 = 0x55 → cycle+1 writes r2, cycle+2 writes r5. `busy[5]` clears at cycle+2.
- Queue full: ALU every cycle, 5 load returns r1..r5 pre-issued → `q_count` reaches 4, `ld_ready = 0`, 5th held. ALU stops → writes r1..r5 in order, one per cycle.
- Scoreboard set and clear together: load r4 written while a new `ld_issue` r4 occurs in the same cycle → `busy[4]` remains 1.
- Reset mid-queue: `q_count = 3`, `busy = 0x0E`, assert `rst` → after the edge `q_count = 0`, `busy = 0`, no later writes.

Source files
------------

// File: rtl/def.sv
// Shared datapath types: register address and a buffered load-return entry.
// Macro fallbacks mirror param.sv so the package is self-contained.
`ifndef Width
`define Width 32
`endif
`ifndef depthReg
`define depthReg 8
`endif

package def;
    typedef logic [$clog2(`depthReg)-1:0] regAddr;

    typedef struct packed {
        regAddr              dest;
        logic [`Width-1:0]   data;
    } wb_entry_t;
endpackage

// File: rtl/param.sv
// Global sizing macros shared by the datapath.
// Guarded so the package can supply the same defaults when compiled on its own.
`ifndef Width
`define Width 32
`endif
`ifndef depthReg
`define depthReg 8
`endif

// File: rtl/wb_fifo.sv
// Circular queue of load-return entries; head is readable combinationally.
// Push into a full queue or pop from an empty one is ignored.
module wb_fifo
    import def::*;
#(
    parameter int QDEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push,
    input  wb_entry_t               push_entry,
    input  logic                    pop,
    output wb_entry_t               head,
    output logic [$clog2(QDEPTH):0] count,
    output logic                    full,
    output logic                    empty
);
    localparam int PTR_W = $clog2(QDEPTH);
    localparam int CNT_W = PTR_W + 1;

    wb_entry_t        mem [QDEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(QDEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (do_pop && !do_push) count <= count - 1'b1;
        end
    end

    // Storage needs no reset: pointers decide what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_entry;
    end
endmodule

// File: rtl/wb_unit.sv
// Register-file write port owner: ALU > queued load > bypassed load, 1-cycle registered write.
// Losing loads are queued; ld_ready drops only when the queue is full.
module wb_unit
    import def::*;
#(
    parameter int WIDTH     = `Width,
    parameter int DEPTH_REG = `depthReg,
    parameter int QDEPTH    = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    alu_valid,
    input  regAddr                  alu_dest,
    input  logic [WIDTH-1:0]        alu_data,
    input  logic                    ld_issue,
    input  regAddr                  ld_issue_dest,
    input  logic                    ld_valid,
    input  regAddr                  ld_dest,
    input  logic [WIDTH-1:0]        ld_data,
    output logic                    ld_ready,
    output logic                    regWrite,
    output regAddr                  writeRegAdd,
    output logic [WIDTH-1:0]        writeRegData,
    output logic [DEPTH_REG-1:0]    busy,
    output logic [$clog2(QDEPTH):0] q_count
);
    wb_entry_t            head;
    wb_entry_t            push_entry;
    logic                 q_full;
    logic                 q_empty;
    logic                 push;
    logic                 pop;
    logic                 alu_req;
    logic                 ld_acc;
    logic                 wr_en;
    regAddr               wr_addr;
    logic [WIDTH-1:0]     wr_data;
    logic [DEPTH_REG-1:0] busy_set;
    logic [DEPTH_REG-1:0] busy_clr;

    assign ld_ready        = rst && !q_full;
    assign alu_req         = alu_valid && (alu_dest != '0);
    assign ld_acc          = ld_valid && ld_ready;
    assign push_entry.dest = ld_dest;
    assign push_entry.data = ld_data;

    wb_fifo #(.QDEPTH(QDEPTH)) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .head       (head),
        .count      (q_count),
        .full       (q_full),
        .empty      (q_empty)
    );

    always_comb begin
        wr_en    = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        push     = 1'b0;
        pop      = 1'b0;
        busy_set = '0;
        busy_clr = '0;
        if (alu_req) begin
            wr_en   = 1'b1;
            wr_addr = alu_dest;
            wr_data = alu_data;
            push    = ld_acc;
        end else if (!q_empty) begin
            // Dest-0 entries still pop, but leave the port idle.
            pop  = 1'b1;
            push = ld_acc;
            if (head.dest != '0) begin
                wr_en             = 1'b1;
                wr_addr           = head.dest;
                wr_data           = head.data;
                busy_clr[head.dest] = 1'b1;
            end
        end else if (ld_acc && (ld_dest != '0)) begin
            wr_en             = 1'b1;
            wr_addr           = ld_dest;
            wr_data           = ld_data;
            busy_clr[ld_dest] = 1'b1;
        end
        if (ld_issue && (ld_issue_dest != '0)) busy_set[ld_issue_dest] = 1'b1;
    end

    // A re-issue to the register being retired this cycle keeps it busy.
    always_ff @(posedge clk) begin
        if (!rst) begin
            regWrite     <= 1'b0;
            writeRegAdd  <= '0;
            writeRegData <= '0;
            busy         <= '0;
        end else begin
            regWrite <= wr_en;
            if (wr_en) begin
                writeRegAdd  <= wr_addr;
                writeRegData <= wr_data;
            end
            busy <= (busy & ~busy_clr) | busy_set;
        end
    end
endmodule

// File: tb/tb_wb_unit.sv
// Directed bench for wb_unit: vector table plus queue-full and reset-mid-queue sequences.
module tb_wb_unit;
    import def::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid;
    regAddr      alu_dest;
    logic [31:0] alu_data;
    logic        ld_issue;
    regAddr      ld_issue_dest;
    logic        ld_valid;
    regAddr      ld_dest;
    logic [31:0] ld_data;
    logic        ld_ready;
    logic        regWrite;
    regAddr      writeRegAdd;
    logic [31:0] writeRegData;
    logic [7:0]  busy;
    logic [2:0]  q_count;

    int n_cmp = 0;
    int n_bad = 0;

    wb_unit #(.WIDTH(32), .DEPTH_REG(8), .QDEPTH(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .alu_valid     (alu_valid),
        .alu_dest      (alu_dest),
        .alu_data      (alu_data),
        .ld_issue      (ld_issue),
        .ld_issue_dest (ld_issue_dest),
        .ld_valid      (ld_valid),
        .ld_dest       (ld_dest),
        .ld_data       (ld_data),
        .ld_ready      (ld_ready),
        .regWrite      (regWrite),
        .writeRegAdd   (writeRegAdd),
        .writeRegData  (writeRegData),
        .busy          (busy),
        .q_count       (q_count)
    );

    always #5 clk = ~clk;

    // Stimulus protocol checks; a re-issue racing the retiring load of the same register is legal.
    always @(posedge clk) begin
        if (rst) begin
            assert (!(ld_issue && ld_issue_dest != 0 && busy[ld_issue_dest]
                      && !(ld_valid && ld_dest == ld_issue_dest)))
                else $error("protocol: issue to busy r%0d", ld_issue_dest);
            assert (!(alu_valid && alu_dest != 0 && busy[alu_dest]))
                else $error("protocol: alu write to busy r%0d", alu_dest);
            assert (!(ld_valid && ld_dest != 0 && !busy[ld_dest]))
                else $error("protocol: load return to idle r%0d", ld_dest);
        end
    end

    typedef struct {
        logic        rst;
        logic        av;
        logic [2:0]  ad;
        logic [31:0] adat;
        logic        li;
        logic [2:0]  lid;
        logic        lv;
        logic [2:0]  ld;
        logic [31:0] ldat;
        logic        e_rw;
        logic [2:0]  e_addr;
        logic [31:0] e_data;
        logic [7:0]  e_busy;
        logic [2:0]  e_q;
        logic        e_rdy;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle();
        alu_valid = 0; alu_dest = 0; alu_data = 0;
        ld_issue = 0; ld_issue_dest = 0;
        ld_valid = 0; ld_dest = 0; ld_data = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int nextld;
        logic acc;
        rst = 0;
        idle();
        //          rst av ad adat          li lid lv ld ldat         rw addr data          busy   q rdy
        vecs[0]  = '{0, 0, 0, 32'h0,        0, 0,  1, 5, 32'h99,      0, 0, 32'h0,          8'h00, 0, 0};
        vecs[1]  = '{0, 0, 0, 32'h0,        0, 0,  1, 5, 32'h99,      0, 0, 32'h0,          8'h00, 0, 0};
        vecs[2]  = '{1, 0, 0, 32'h0,        0, 0,  0, 0, 32'h0,       0, 0, 32'h0,          8'h00, 0, 1};
        vecs[3]  = '{1, 1, 3, 32'hDEADBEEF, 0, 0,  0, 0, 32'h0,       1, 3, 32'hDEADBEEF,   8'h00, 0, 1};
        vecs[4]  = '{1, 1, 0, 32'h1234,     0, 0,  0, 0, 32'h0,       0, 3, 32'hDEADBEEF,   8'h00, 0, 1};
        vecs[5]  = '{1, 0, 0, 32'h0,        1, 5,  0, 0, 32'h0,       0, 3, 32'hDEADBEEF,   8'h20, 0, 1};
        vecs[6]  = '{1, 1, 2, 32'h11,       0, 0,  1, 5, 32'h55,      1, 2, 32'h11,         8'h20, 1, 1};
        vecs[7]  = '{1, 0, 0, 32'h0,        0, 0,  0, 0, 32'h0,       1, 5, 32'h55,         8'h00, 0, 1};
        vecs[8]  = '{1, 0, 0, 32'h0,        0, 0,  0, 0, 32'h0,       0, 5, 32'h55,         8'h00, 0, 1};
        vecs[9]  = '{1, 0, 0, 32'h0,        1, 6,  0, 0, 32'h0,       0, 5, 32'h55,         8'h40, 0, 1};
        vecs[10] = '{1, 0, 0, 32'h0,        0, 0,  1, 6, 32'h66,      1, 6, 32'h66,         8'h00, 0, 1};
        vecs[11] = '{1, 0, 0, 32'h0,        1, 4,  0, 0, 32'h0,       0, 6, 32'h66,         8'h10, 0, 1};
        vecs[12] = '{1, 0, 0, 32'h0,        1, 4,  1, 4, 32'h44,      1, 4, 32'h44,         8'h10, 0, 1};
        vecs[13] = '{1, 0, 0, 32'h0,        0, 0,  1, 4, 32'h45,      1, 4, 32'h45,         8'h00, 0, 1};
        vecs[14] = '{1, 0, 0, 32'h0,        0, 0,  0, 0, 32'h0,       0, 4, 32'h45,         8'h00, 0, 1};

        for (int i = 0; i < 15; i++) begin
            rst = vecs[i].rst;
            alu_valid = vecs[i].av; alu_dest = vecs[i].ad; alu_data = vecs[i].adat;
            ld_issue = vecs[i].li; ld_issue_dest = vecs[i].lid;
            ld_valid = vecs[i].lv; ld_dest = vecs[i].ld; ld_data = vecs[i].ldat;
            step();
            chk($sformatf("v%0d regWrite", i), 32'(regWrite), 32'(vecs[i].e_rw));
            chk($sformatf("v%0d addr", i), 32'(writeRegAdd), 32'(vecs[i].e_addr));
            chk($sformatf("v%0d data", i), writeRegData, vecs[i].e_data);
            chk($sformatf("v%0d busy", i), 32'(busy), 32'(vecs[i].e_busy));
            chk($sformatf("v%0d q_count", i), 32'(q_count), 32'(vecs[i].e_q));
            chk($sformatf("v%0d ld_ready", i), 32'(ld_ready), 32'(vecs[i].e_rdy));
        end

        // Queue fill under sustained ALU traffic, then in-order drain.
        idle();
        for (int r = 1; r <= 5; r++) begin
            ld_issue = 1; ld_issue_dest = 3'(r);
            step();
        end
        idle();
        step();
        chk("qf busy issued", 32'(busy), 32'h3E);
        nextld = 1;
        for (int c = 0; c < 6; c++) begin
            alu_valid = 1; alu_dest = 7; alu_data = 32'h700 + c;
            ld_valid = (nextld <= 5); ld_dest = 3'(nextld); ld_data = 32'h100 + nextld;
            acc = ld_valid && ld_ready;
            step();
            if (acc) nextld++;
            chk($sformatf("qf alu%0d addr", c), 32'(writeRegAdd), 32'd7);
            chk($sformatf("qf alu%0d data", c), writeRegData, 32'h700 + c);
        end
        chk("qf q_count full", 32'(q_count), 32'd4);
        chk("qf ld_ready full", 32'(ld_ready), 32'd0);
        chk("qf busy held", 32'(busy), 32'h3E);
        alu_valid = 0; alu_dest = 0; alu_data = 0;
        for (int k = 1; k <= 5; k++) begin
            ld_valid = (nextld <= 5); ld_dest = 3'(nextld); ld_data = 32'h100 + nextld;
            acc = ld_valid && ld_ready;
            step();
            if (acc) nextld++;
            chk($sformatf("qf drain%0d rw", k), 32'(regWrite), 32'd1);
            chk($sformatf("qf drain%0d addr", k), 32'(writeRegAdd), 32'(k));
            chk($sformatf("qf drain%0d data", k), writeRegData, 32'h100 + k);
        end
        idle();
        step();
        chk("qf end rw", 32'(regWrite), 32'd0);
        chk("qf end q_count", 32'(q_count), 32'd0);
        chk("qf end busy", 32'(busy), 32'h00);

        // Reset with three queued loads outstanding.
        for (int r = 1; r <= 3; r++) begin
            ld_issue = 1; ld_issue_dest = 3'(r);
            step();
        end
        ld_issue = 0; ld_issue_dest = 0;
        for (int r = 1; r <= 3; r++) begin
            alu_valid = 1; alu_dest = 7; alu_data = 32'hA0 + r;
            ld_valid = 1; ld_dest = 3'(r); ld_data = 32'h200 + r;
            step();
        end
        idle();
        alu_valid = 1; alu_dest = 7; alu_data = 32'hBB;
        step();
        chk("rq q_count", 32'(q_count), 32'd3);
        chk("rq busy", 32'(busy), 32'h0E);
        idle();
        rst = 0;
        step();
        chk("rq rst q_count", 32'(q_count), 32'd0);
        chk("rq rst busy", 32'(busy), 32'h00);
        chk("rq rst rw", 32'(regWrite), 32'd0);
        chk("rq rst ld_ready", 32'(ld_ready), 32'd0);
        rst = 1;
        for (int c = 0; c < 4; c++) begin
            step();
            chk($sformatf("rq post%0d rw", c), 32'(regWrite), 32'd0);
            chk($sformatf("rq post%0d q_count", c), 32'(q_count), 32'd0);
        end
        chk("rq post ld_ready", 32'(ld_ready), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
